// File: rtl/grayscale_stream_ctrl.sv
// grayscale_stream_ctrl
// Pairs incoming 32-bit RGB565 words (two pixels each) and emits one packed
// 32-bit word of four 8-bit gray pixels per pair. Frame length, start, abort
// and status are handled through a CPU custom-instruction port.
module grayscale_stream_ctrl #(
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int unsigned CNT_WIDTH           = 20
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  isId,
  output logic        done,
  output logic [31:0] result,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        m_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD0 = 2'd1,
    WORD1 = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PIX_STEP  = CNT_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] WORD_STEP = CNT_WIDTH'(1);

  localparam logic [2:0] OP_STATUS = 3'd0;
  localparam logic [2:0] OP_SIZE   = 3'd1;
  localparam logic [2:0] OP_GO     = 3'd2;
  localparam logic [2:0] OP_ABORT  = 3'd3;
  localparam logic [2:0] OP_WORDS  = 3'd4;

  state_t               state;
  logic [31:0]          word0;
  logic [CNT_WIDTH-1:0] pixels_in;
  logic [CNT_WIDTH-1:0] words_emitted;
  logic [CNT_WIDTH-1:0] frame_size;
  logic                 frame_done;
  logic                 err;

  logic                 sel;
  logic [2:0]           op;
  logic                 op_size;
  logic                 op_go;
  logic                 op_abort;
  logic                 busy;
  logic                 frame_ok;
  logic                 pair_last;
  logic                 in_fire;
  logic                 out_fire;
  logic [31:0]          gray_word;
  logic                 unused_bits;

  // RGB565 (byte-swapped) pixel to 8-bit luma: y = (54r + 183g + 19b) >> 6
  function automatic logic [7:0] gray(input logic [15:0] p);
    logic [5:0]  r;
    logic [5:0]  g;
    logic [5:0]  b;
    logic [13:0] acc;
    r   = {p[7:3], 1'b0};
    g   = {p[2:0], p[15:13]};
    b   = {p[12:8], 1'b0};
    acc = 14'd54 * {8'b0, r} + 14'd183 * {8'b0, g} + 14'd19 * {8'b0, b};
    return 8'(acc >> 6);
  endfunction

  assign sel      = start && (isId == customInstructionId);
  assign op       = valueA[2:0];
  assign done     = sel;
  assign op_size  = sel && (op == OP_SIZE);
  assign op_go    = sel && (op == OP_GO);
  assign op_abort = sel && (op == OP_ABORT);

  assign busy      = (state != IDLE) || m_valid;
  assign frame_ok  = (frame_size != '0) && (frame_size[1:0] == 2'b00);
  assign pair_last = ((pixels_in + PIX_STEP) == frame_size);
  assign in_fire   = s_valid && s_ready;
  assign out_fire  = m_valid && m_ready;

  assign gray_word = {gray(s_data[31:16]), gray(s_data[15:0]),
                      gray(word0[31:16]),  gray(word0[15:0])};

  assign unused_bits = ^{valueA[31:3], valueB[31:CNT_WIDTH]};

  // Input acceptance: always open for the first word, second word only when the output register can take the result
  always_comb begin
    s_ready = 1'b0;
    case (state)
      WORD0:   s_ready = 1'b1;
      WORD1:   s_ready = !m_valid || m_ready;
      default: s_ready = 1'b0;
    endcase
  end

  // Custom-instruction read mux; zero whenever the instruction is not addressed to this block
  always_comb begin
    result = '0;
    if (sel) begin
      case (op)
        OP_STATUS: result = {28'b0, err, frame_done, busy, m_valid};
        OP_WORDS:  result = 32'(words_emitted);
        default:   result = '0;
      endcase
    end
  end

  // Frame sequencer, output register and CI-visible state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      word0         <= '0;
      pixels_in     <= '0;
      words_emitted <= '0;
      frame_size    <= '0;
      frame_done    <= 1'b0;
      err           <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_last        <= 1'b0;
    end else begin
      if (out_fire) begin
        words_emitted <= words_emitted + WORD_STEP;
        m_valid       <= 1'b0;
        m_last        <= 1'b0;
        if (m_last) begin
          frame_done <= 1'b1;
        end
      end

      if (op_size && !busy) begin
        frame_size <= valueB[CNT_WIDTH-1:0];
      end

      if (op_abort) begin
        // Abort still lets a word handshaken this cycle be counted above, but drops everything else in flight
        state      <= IDLE;
        word0      <= '0;
        m_valid    <= 1'b0;
        m_last     <= 1'b0;
        frame_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (op_go && !busy) begin
              pixels_in     <= '0;
              words_emitted <= '0;
              frame_done    <= 1'b0;
              if (frame_ok) begin
                err   <= 1'b0;
                state <= WORD0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          WORD0: begin
            if (in_fire) begin
              word0 <= s_data;
              state <= WORD1;
            end
          end
          WORD1: begin
            if (in_fire) begin
              m_data    <= gray_word;
              m_valid   <= 1'b1;
              m_last    <= pair_last;
              pixels_in <= pixels_in + PIX_STEP;
              state     <= pair_last ? IDLE : WORD0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grayscale_stream_ctrl.sv
// Testbench for grayscale_stream_ctrl: scoreboard of expected gray words fed by
// a pixel-level reference model, popped by an independent output monitor.
`timescale 1ns/1ps
module tb_grayscale_stream_ctrl;

  localparam logic [7:0]  CI_ID = 8'h5A;
  localparam int unsigned CW    = 20;

  logic        clock   = 1'b0;
  logic        resetn  = 1'b1;
  logic        start   = 1'b0;
  logic [31:0] valueA  = '0;
  logic [31:0] valueB  = '0;
  logic [7:0]  isId    = '0;
  logic        done;
  logic [31:0] result;
  logic        s_valid = 1'b0;
  logic [31:0] s_data  = '0;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready = 1'b0;

  grayscale_stream_ctrl #(
    .customInstructionId(CI_ID),
    .CNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .start(start),
    .valueA(valueA),
    .valueB(valueB),
    .isId(isId),
    .done(done),
    .result(result),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  int          ready_mode = 0;   // 0 always ready, 1 random, 2 stuck low
  int          cycle = 0;
  bit          spacing_on = 0;
  int          prev_hs = -1;
  logic [31:0] last_out = '0;
  logic        last_out_last = 1'b0;

  // reference model state: pending first word of a pair and pixel progress
  logic [31:0] mdl_w0 = '0;
  bit          mdl_half = 0;
  int          mdl_pix = 0;
  int          mdl_size = 0;

  function automatic int gray_px(input int p);
    int r;
    int g;
    int b;
    r = ((p >> 3) & 31) * 2;
    g = ((p & 7) << 3) | ((p >> 13) & 7);
    b = ((p >> 8) & 31) * 2;
    return (54 * r + 183 * g + 19 * b) / 64;
  endfunction

  function automatic logic [31:0] gray_pair(input logic [31:0] a, input logic [31:0] b);
    int          px[4];
    logic [31:0] w;
    px[0] = int'(a[15:0]);
    px[1] = int'(a[31:16]);
    px[2] = int'(b[15:0]);
    px[3] = int'(b[31:16]);
    w = '0;
    for (int k = 0; k < 4; k++) w = w | (32'(gray_px(px[k])) << (8 * k));
    return w;
  endfunction

  always @(posedge clock) cycle <= cycle + 1;

  // downstream sink: drives m_ready on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // output monitor: a handshake is decided by values settled mid-low-phase
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (resetn && m_valid && m_ready) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got %h last %0b required no word", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.data || m_last !== e.last) begin
            errors++;
            $display("FAIL out_word got %h last %0b required %h last %0b", m_data, m_last, e.data, e.last);
          end
        end
        if (spacing_on) begin
          if (prev_hs >= 0) begin
            checks++;
            if (cycle - prev_hs != 2) begin
              errors++;
              $display("FAIL out_spacing got %0d required 2", cycle - prev_hs);
            end
          end
          prev_hs = cycle;
        end
        last_out      = m_data;
        last_out_last = m_last;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  task automatic ci(input logic [2:0] op, input logic [31:0] data, output logic [31:0] rd);
    @(negedge clock);
    start  = 1'b1;
    isId   = CI_ID;
    valueA = {29'b0, op};
    valueB = data;
    #1;
    chk("ci_done", 32'(done), 32'd1);
    rd = result;
    @(posedge clock);
    #1;
    start  = 1'b0;
    valueA = '0;
    valueB = '0;
  endtask

  task automatic start_frame(input int size);
    logic [31:0] rd;
    ci(3'd1, 32'(size), rd);
    ci(3'd2, 32'd0, rd);
    mdl_size = size;
    mdl_pix  = 0;
    mdl_half = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clock);
    s_valid = 1'b1;
    s_data  = w;
    #1;
    while (!s_ready && n < 2000) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got s_ready 0 required 1");
      s_valid = 1'b0;
      return;
    end
    if (!mdl_half) begin
      mdl_w0   = w;
      mdl_half = 1;
    end else begin
      mdl_half = 0;
      mdl_pix += 4;
      e.data = gray_pair(mdl_w0, w);
      e.last = (mdl_pix == mdl_size);
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
      @(negedge clock);
      #3;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || m_valid) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout required completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] tw[8];
    int          sz;

    // reset state
    #2 resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    resetn = 1'b1;
    ci(3'd0, 0, rd); chk("rst_status", rd, 32'h0);
    ci(3'd4, 0, rd); chk("rst_words", rd, 32'd0);

    // directed single-word frame
    ready_mode = 0;
    start_frame(4);
    send_word(32'hE00700F8);
    send_word(32'hFFFF1F00);
    wait_drain();
    chk("t2_data", last_out, 32'hFA12B434);
    chk("t2_last", 32'(last_out_last), 32'd1);
    ci(3'd0, 0, rd); chk("t2_status", rd, 32'h4);
    ci(3'd4, 0, rd); chk("t2_words", rd, 32'd1);

    // not addressed: done low and result zero even though status is nonzero
    @(negedge clock);
    start = 1'b1; isId = CI_ID + 8'd1; valueA = '0;
    #1;
    chk("nosel_done", 32'(done), 32'd0);
    chk("nosel_result", result, 32'd0);
    start = 1'b0; isId = '0;
    for (int op = 5; op < 8; op++) begin
      ci(3'(op), 32'hFFFF_FFFF, rd);
      chk("op5to7_read", rd, 32'd0);
    end

    // invalid frame size
    ci(3'd1, 32'd6, rd);
    ci(3'd2, 0, rd);
    ci(3'd0, 0, rd); chk("t4_status", rd, 32'h8);
    @(negedge clock);
    s_valid = 1'b1;
    #1 chk("t4_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;

    // downstream backpressure
    for (int i = 0; i < 8; i++) tw[i] = $urandom;
    ready_mode = 2;
    start_frame(16);
    send_word(tw[0]);
    send_word(tw[1]);
    send_word(tw[2]);
    @(negedge clock);
    s_valid = 1'b1;
    s_data  = tw[3];
    repeat (3) begin
      #1;
      chk("t3_s_ready", 32'(s_ready), 32'd0);
      chk("t3_m_valid", 32'(m_valid), 32'd1);
      chk("t3_hold", m_data, exp_q[0].data);
      @(negedge clock);
    end
    ready_mode = 0;
    for (int i = 3; i < 8; i++) send_word(tw[i]);
    wait_drain();
    ci(3'd4, 0, rd); chk("t3_words", rd, 32'd4);
    ci(3'd0, 0, rd); chk("t3_status", rd, 32'h4);

    // abort after three input words
    start_frame(8);
    for (int i = 0; i < 3; i++) send_word($urandom);
    wait_drain();
    ci(3'd3, 0, rd);
    mdl_half = 0;
    ci(3'd0, 0, rd); chk("t5_status", rd, 32'h0);
    ci(3'd4, 0, rd); chk("t5_words", rd, 32'd1);
    @(negedge clock);
    s_valid = 1'b1;
    #1 chk("t5_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    start_frame(8);
    for (int i = 0; i < 4; i++) send_word($urandom);
    wait_drain();
    ci(3'd4, 0, rd); chk("t5_restart_words", rd, 32'd2);
    ci(3'd0, 0, rd); chk("t5_restart_status", rd, 32'h4);

    // abort while an output word is stalled
    ready_mode = 2;
    start_frame(8);
    send_word($urandom);
    send_word($urandom);
    ci(3'd3, 0, rd);
    #1 chk("abort_m_valid", 32'(m_valid), 32'd0);
    exp_q.delete();
    mdl_half = 0;
    ready_mode = 0;
    ci(3'd4, 0, rd); chk("abort_words", rd, 32'd0);

    // asynchronous reset mid-frame
    ready_mode = 2;
    start_frame(8);
    send_word($urandom);
    send_word($urandom);
    @(negedge clock);
    #2;
    chk("t1_pre_m_valid", 32'(m_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t1_m_valid", 32'(m_valid), 32'd0);
    chk("t1_s_ready", 32'(s_ready), 32'd0);
    exp_q.delete();
    mdl_half = 0;
    @(negedge clock);
    resetn = 1'b1;
    ready_mode = 0;
    ci(3'd0, 0, rd); chk("t1_status", rd, 32'h0);
    ci(3'd4, 0, rd); chk("t1_words", rd, 32'd0);

    // randomized frames with random backpressure and input gaps
    ready_mode = 1;
    repeat (6) begin
      sz = 4 * int'($urandom_range(1, 16));
      start_frame(sz);
      for (int i = 0; i < sz / 2; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        send_word($urandom);
      end
      wait_drain();
      ci(3'd4, 0, rd); chk("rand_words", rd, 32'(sz / 4));
      ci(3'd0, 0, rd); chk("rand_status", rd, 32'h4);
    end

    // full-throughput white frame
    ready_mode = 0;
    start_frame(400);
    spacing_on = 1;
    prev_hs = -1;
    repeat (200) send_word(32'hFFFF_FFFF);
    wait_drain();
    spacing_on = 0;
    chk("t6_data", last_out, 32'hFAFA_FAFA);
    chk("t6_last", 32'(last_out_last), 32'd1);
    ci(3'd4, 0, rd); chk("t6_words", rd, 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
